// File: rtl/sram_pkg.sv
// Shared types and constants for the pixel-clock SRAM arbiter.
package sram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [2:0] RD_START = 3'd0;
  localparam logic [2:0] RD_LAST  = 3'd3;
  localparam logic [2:0] WR_START = 3'd4;
  localparam logic [2:0] WE_FIRST = 3'd5;
  localparam logic [2:0] WE_LAST  = 3'd6;
  localparam logic [2:0] WR_LAST  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENG  = 2'd1,
    CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/sram_phase_gen.sv
// Eight-phase frame counter; phase_next lets the arbiter register outputs for the coming phase.
module sram_phase_gen
  import sram_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       rst,
  input  logic       phase_sync,
  output logic [2:0] phase,
  output logic [2:0] phase_next
);

  assign phase_next = (rst || phase_sync) ? RD_START : phase + 3'd1;

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      phase <= RD_START;
    end else begin
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Time-slotted SRAM arbiter: a read slot (phases 0-3) and a write slot (phases 4-7) per frame,
// shared between the pixel engine and a CPU port with starvation protection for CPU writes.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = 19'h7FFFF,
  parameter int                STARVE_SLOTS = 4
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              phase_sync,
  input  logic              eng_rd_en,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_data,
  output logic              eng_rd_valid,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  output logic              eng_wr_drop,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_drive,
  output logic              ram_cel,
  output logic              ram_oel,
  output logic              ram_wel
);

  localparam int              CNT_W      = $clog2(STARVE_SLOTS + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_SLOTS);

  logic [2:0]       phase;
  logic [2:0]       phase_next;
  owner_t           rd_owner;
  owner_t           wr_owner;
  owner_t           rd_pick;
  owner_t           wr_pick;
  logic [CNT_W-1:0] starve_cnt;
  logic             cpu_armed;
  logic             cpu_rd_pend;
  logic             cpu_wr_pend;
  logic             force_cpu;

  sram_phase_gen u_phase_gen (
    .clk_pixel  (clk_pixel),
    .rst        (rst),
    .phase_sync (phase_sync),
    .phase      (phase),
    .phase_next (phase_next)
  );

  assign cpu_rd_pend = cpu_req && cpu_rnw && cpu_armed;
  assign cpu_wr_pend = cpu_req && !cpu_rnw && cpu_armed;
  assign force_cpu   = cpu_wr_pend && (starve_cnt == STARVE_MAX);

  always_comb begin
    rd_pick = IDLE;
    if (eng_rd_en)        rd_pick = ENG;
    else if (cpu_rd_pend) rd_pick = CPU;

    wr_pick = IDLE;
    if (force_cpu)        wr_pick = CPU;
    else if (eng_wr_en)   wr_pick = ENG;
    else if (cpu_wr_pend) wr_pick = CPU;
  end

  // Bus outputs are registered for the phase about to start, so slot decisions
  // sample the inputs on the edge that enters phase 0 or phase 4.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      rd_owner     <= IDLE;
      wr_owner     <= IDLE;
      starve_cnt   <= '0;
      cpu_armed    <= 1'b1;
      ram_cel      <= 1'b1;
      ram_oel      <= 1'b1;
      ram_wel      <= 1'b1;
      ram_drive    <= 1'b0;
      ram_addr     <= IDLE_ADDR;
      ram_dout     <= '0;
      eng_rd_valid <= 1'b0;
      eng_rd_data  <= '0;
      eng_wr_drop  <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      eng_rd_valid <= 1'b0;
      eng_wr_drop  <= 1'b0;
      cpu_ack      <= 1'b0;

      if (!cpu_req) cpu_armed <= 1'b1;

      // Only a read slot that really reaches the end of phase 3 returns data.
      if (phase == RD_LAST && phase_next == WR_START) begin
        if (rd_owner == ENG) begin
          eng_rd_data  <= ram_din;
          eng_rd_valid <= 1'b1;
        end else if (rd_owner == CPU) begin
          cpu_rdata <= ram_din;
          cpu_ack   <= 1'b1;
        end
      end

      if (phase == WE_LAST && phase_next == WR_LAST && wr_owner == CPU) cpu_ack <= 1'b1;

      case (phase_next)
        RD_START: begin
          rd_owner  <= rd_pick;
          ram_wel   <= 1'b1;
          ram_drive <= 1'b0;
          if (rd_pick == IDLE) begin
            ram_cel  <= 1'b1;
            ram_oel  <= 1'b1;
            ram_addr <= IDLE_ADDR;
          end else begin
            ram_cel  <= 1'b0;
            ram_oel  <= 1'b0;
            ram_addr <= (rd_pick == ENG) ? eng_rd_addr : cpu_addr;
          end
          if (rd_pick == CPU) begin
            starve_cnt <= '0;
            cpu_armed  <= 1'b0;
          end
        end

        WR_START: begin
          wr_owner    <= wr_pick;
          eng_wr_drop <= force_cpu && eng_wr_en;
          ram_oel     <= 1'b1;
          ram_wel     <= 1'b1;
          ram_drive   <= 1'b0;
          case (wr_pick)
            ENG: begin
              ram_cel  <= 1'b0;
              ram_addr <= eng_wr_addr;
              ram_dout <= eng_wr_data;
              if (cpu_wr_pend && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
            end
            CPU: begin
              ram_cel    <= 1'b0;
              ram_addr   <= cpu_addr;
              ram_dout   <= cpu_wdata;
              starve_cnt <= '0;
              cpu_armed  <= 1'b0;
            end
            default: begin
              ram_cel  <= 1'b1;
              ram_addr <= IDLE_ADDR;
            end
          endcase
        end

        WE_FIRST: begin
          if (wr_owner != IDLE) begin
            ram_wel   <= 1'b0;
            ram_drive <= 1'b1;
          end
        end

        WR_LAST: begin
          ram_wel <= 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule
